// File: rtl/io_bus_if.sv
// io_bus_if: CPU IO-port bundle (address, write data/strobe, combinational read data).
interface io_bus_if;
  logic [31:0] io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic [31:0] io_din;
  modport master (output io_addr, io_dout, io_we, input io_din);
  modport slave (input io_addr, io_dout, io_we, output io_din);
endinterface

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped LED/switch/UART-TX controller on the CPU IO port.
// Define IO_CYCLE_CNT_EN to include the 32-bit free-running cycle counter at 0x10.
module io_bus_ctrl #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_W      = 16,
  parameter int SW_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  io_bus_if.slave          bus,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e            state_q, state_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [SW_W-1:0]   sw1_q, sw1_d, sw2_q, sw2_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d, tx_q, tx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic [31:0]       cyc_rd;
  logic [7:0]        a;
  logic              wr_led, wr_tx, wr_stat, full, empty, push, pop, busy, last, unused;
  assign a       = bus.io_addr[7:0];
  assign wr_led  = bus.io_we && a == 8'h00;
  assign wr_tx   = bus.io_we && a == 8'h08;
  assign wr_stat = bus.io_we && a == 8'h0C;
  assign full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty   = wr_ptr_q == rd_ptr_q;
  assign push    = wr_tx && !full;
  assign pop     = state_q == IDLE && !empty;
  assign busy    = state_q != IDLE;
  assign last    = cnt_q == CW'(CLK_DIV - 1);
  assign led     = led_q;
  assign uart_tx = tx_q;
  assign unused  = &{1'b0, bus.io_addr[31:8], bus.io_dout[31:8]};
  always_comb begin
    led_d    = wr_led ? bus.io_dout[LED_W-1:0] : led_q;
    sw1_d    = sw;
    sw2_d    = sw1_q;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = bus.io_dout[7:0];
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    // a dropped push and a clear in the same cycle leave overflow set
    ovf_d    = (wr_tx && full) ? 1'b1 : (wr_stat && bus.io_dout[3]) ? 1'b0 : ovf_q;
  end
  always_comb begin
    state_d = state_q == IDLE ? (empty ? IDLE : START) :
              !last           ? state_q :
              state_q == START ? DATA :
              state_q == DATA  ? (bit_q == 3'd7 ? STOP : DATA) : IDLE;
  end
  // uart_tx is registered from the next state so the line tracks state_q exactly
  always_comb begin
    cnt_d = (state_q == IDLE || last) ? '0 : cnt_q + CW'(1);
    bit_d = state_q != DATA ? 3'd0 : bit_q + 3'(last);
    sh_d  = pop ? mem_q[rd_ptr_q[AW-1:0]] : (state_q == DATA && last) ? {1'b0, sh_q[7:1]} : sh_q;
    tx_d  = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      led_q    <= '0;
      sw1_q    <= '0;
      sw2_q    <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      sw1_q    <= sw1_d;
      sw2_q    <= sw2_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
    end
  end
`ifdef IO_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  assign cyc_d  = (bus.io_we && a == 8'h10) ? '0 : cyc_q + 32'd1;
  assign cyc_rd = cyc_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end
`else
  assign cyc_rd = '0;
`endif
  assign bus.io_din = a == 8'h00 ? 32'(led_q) :
                      a == 8'h04 ? 32'(sw2_q) :
                      a == 8'h0C ? {28'd0, ovf_q, busy, empty, full} :
                      a == 8'h10 ? cyc_rd : 32'd0;
endmodule
